// File: rtl/cache_read_arbiter_if.sv
// Requester handshake, broadcast response and cache read port of cache_read_arbiter.
// The master side is the requester/cache environment; the slave side is the arbiter.
interface cache_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      cache_rd_en;
    logic [ADDR_W-1:0]         cache_rd_addr;
    logic [DATA_W-1:0]         cache_rd_data;
    logic                      busy;

    modport master (
        output req_valid, req_lock, req_addr, cache_rd_data,
        input  req_ready, rsp_valid, rsp_data, cache_rd_en, cache_rd_addr, busy
    );

    modport slave (
        input  req_valid, req_lock, req_addr, cache_rd_data,
        output req_ready, rsp_valid, rsp_data, cache_rd_en, cache_rd_addr, busy
    );
endinterface

// File: rtl/cache_read_arbiter.sv
// Shares one fixed-latency cache read port among NUM_REQ requesters with burst locking.
// The winner's index rides a tag pipeline so read data is steered back to its issuer.
module cache_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2,
    parameter int RR_MODE = 1
) (
    input  logic           clk,
    input  logic           resetn,
    cache_read_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t                       ptr;
    idx_t                       lock_owner;
    logic                       lock_held;
    idx_t                       gnt_idx;
    idx_t                       cand_idx;
    logic                       gnt_any;
    logic [NUM_REQ-1:0]         ready;
    logic [RD_LAT:0]            vld_pipe;
    logic [RD_LAT:0][IDX_W-1:0] tag_pipe;
    logic [ADDR_W-1:0]          rd_addr;
    logic [NUM_REQ-1:0]         rsp_vld;

    // A held lock masks every other requester; otherwise scan from ptr (RR) or from 0.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        if (lock_held) begin
            gnt_any = bus.req_valid[lock_owner];
            gnt_idx = lock_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (RR_MODE != 0)
                    cand_idx = idx_t'((int'(ptr) + k) % NUM_REQ);
                else
                    cand_idx = idx_t'(k);
                if (!gnt_any && bus.req_valid[cand_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (gnt_any) ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr        <= '0;
            lock_held  <= 1'b0;
            lock_owner <= '0;
            rd_addr    <= '0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], gnt_any};
            tag_pipe <= {tag_pipe[RD_LAT-1:0], gnt_idx};
            if (gnt_any) begin
                rd_addr <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                if (bus.req_lock[gnt_idx]) begin
                    lock_held  <= 1'b1;
                    lock_owner <= gnt_idx;
                end else begin
                    // Releasing (or unlocked) beat: only now does the RR pointer move on.
                    lock_held <= 1'b0;
                    if (RR_MODE != 0)
                        ptr <= idx_t'((int'(gnt_idx) + 1) % NUM_REQ);
                end
            end
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (vld_pipe[RD_LAT]) rsp_vld[tag_pipe[RD_LAT]] = 1'b1;
    end

    assign bus.req_ready     = ready;
    assign bus.cache_rd_en   = vld_pipe[0];
    assign bus.cache_rd_addr = rd_addr;
    assign bus.rsp_valid     = rsp_vld;
    assign bus.rsp_data      = bus.cache_rd_data;
    assign bus.busy          = lock_held | (|vld_pipe);
endmodule

// File: tb/tb_cache_read_arbiter.sv
// Bench for cache_read_arbiter: a round-robin DUT (RD_LAT=2) and a fixed-priority DUT
// (RD_LAT=4), both 4 requesters, share stimulus and are checked against a grant/queue model.
module tb_cache_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    valid;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;

    cache_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    cache_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    cache_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .RR_MODE(1))
        dut_rr (.clk(clk), .resetn(resetn), .bus(bus_a));
    cache_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .RR_MODE(0))
        dut_fp (.clk(clk), .resetn(resetn), .bus(bus_b));

    assign bus_a.req_valid = valid;
    assign bus_a.req_lock  = lock;
    assign bus_a.req_addr  = addr;
    assign bus_b.req_valid = valid;
    assign bus_b.req_lock  = lock;
    assign bus_b.req_addr  = addr;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Cache model: returns mem_f(address) exactly LAT cycles after the address is presented.
    logic [AW-1:0] hist_a [4];
    logic [AW-1:0] hist_b [4];
    always @(posedge clk) begin
        hist_a[0] <= bus_a.cache_rd_addr;
        hist_b[0] <= bus_b.cache_rd_addr;
        for (int i = 1; i < 4; i++) begin
            hist_a[i] <= hist_a[i-1];
            hist_b[i] <= hist_b[i-1];
        end
    end
    assign bus_a.cache_rd_data = mem_f(hist_a[LAT_A-1]);
    assign bus_b.cache_rd_data = mem_f(hist_b[LAT_B-1]);

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model, index 0 = round-robin DUT, 1 = fixed-priority DUT.
    int            m_ptr [2];
    bit            m_lk [2];
    int            m_own [2];
    bit            m_en [2];
    logic [AW-1:0] m_addr [2];
    int            m_nfly [2];
    int            r_tag [2][16];
    logic [AW-1:0] r_addr [2][16];

    logic [N-1:0]  cap_ready [2];
    logic [N-1:0]  cap_rsp [2];
    logic          cap_en [2];
    logic          cap_busy [2];
    logic [AW-1:0] cap_addr [2];

    function automatic int lat(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic model_reset(input int k);
        m_ptr[k] = 0; m_lk[k] = 0; m_own[k] = 0; m_en[k] = 0; m_addr[k] = '0; m_nfly[k] = 0;
        for (int s = 0; s < 16; s++) r_tag[k][s] = -1;
    endtask

    function automatic int model_grant(input int k);
        if (m_lk[k]) return valid[m_own[k]] ? m_own[k] : -1;
        for (int j = 0; j < N; j++) begin
            int i;
            i = (k == 0) ? (m_ptr[k] + j) % N : j;
            if (valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input int k, input logic [N-1:0] rdy, input logic en, input logic [AW-1:0] ca,
                       input logic [N-1:0] rsp, input logic [DW-1:0] dat, input logic bsy);
        int g, slot, t;
        logic [N-1:0] er, ersp;
        string p;
        p = (k == 0) ? "rr" : "fp";
        slot = cyc % 16;
        g = model_grant(k);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        t = r_tag[k][slot];
        ersp = '0;
        if (t >= 0) ersp[t] = 1'b1;
        ck({p, " req_ready"}, rdy, er);
        ck({p, " ready one-hot"}, ($countones(rdy) <= 1), 1);
        ck({p, " cache_rd_en"}, en, m_en[k]);
        ck({p, " cache_rd_addr"}, ca, m_addr[k]);
        ck({p, " rsp_valid"}, rsp, ersp);
        if (t >= 0) ck({p, " rsp_data"}, dat, mem_f(r_addr[k][slot]));
        ck({p, " busy"}, bsy, (m_lk[k] || m_nfly[k] > 0));
        cap_ready[k] = rdy; cap_rsp[k] = rsp; cap_en[k] = en; cap_busy[k] = bsy; cap_addr[k] = ca;
        if (resetn) begin
            if (t >= 0) begin m_nfly[k]--; r_tag[k][slot] = -1; end
            m_en[k] = (g >= 0);
            if (g >= 0) begin
                m_addr[k] = addr[g*AW +: AW];
                m_nfly[k]++;
                r_tag[k][(cyc + 1 + lat(k)) % 16] = g;
                r_addr[k][(cyc + 1 + lat(k)) % 16] = addr[g*AW +: AW];
                if (lock[g]) begin
                    m_lk[k] = 1; m_own[k] = g;
                end else begin
                    m_lk[k] = 0;
                    if (k == 0) m_ptr[k] = (g + 1) % N;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!resetn) begin model_reset(0); model_reset(1); end
        chk(0, bus_a.req_ready, bus_a.cache_rd_en, bus_a.cache_rd_addr, bus_a.rsp_valid, bus_a.rsp_data, bus_a.busy);
        chk(1, bus_b.req_ready, bus_b.cache_rd_en, bus_b.cache_rd_addr, bus_b.rsp_valid, bus_b.rsp_data, bus_b.busy);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = '0; lock = '0;
        repeat (n) step();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_fp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b1111, 4'b0001};
        tbl[2] = '{4'b1110, 4'b0010};
        tbl[3] = '{4'b1100, 4'b0100};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b1010, 4'b0010};
        tbl[6] = '{4'b0101, 4'b0001};
        tbl[7] = '{4'b0110, 4'b0010};

        valid = '0; lock = '0;
        addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        model_reset(0); model_reset(1);
        repeat (2) step();
        resetn = 1'b1;

        // Two requesters streaming: grants alternate, responses 3 cycles after accept.
        valid = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            ck("rr alternate grant", cap_ready[0], (i % 2) ? 4'b0010 : 4'b0001);
            if (i >= 1) ck("rr issue addr", cap_addr[0], (i % 2) ? 16'h0010 : 16'h0020);
            if (i >= 3) ck("rr rsp alternate", cap_rsp[0], ((i - 3) % 2) ? 4'b0010 : 4'b0001);
        end
        idle(6);

        // Fixed-priority decode table.
        for (int i = 0; i < 8; i++) begin
            valid = tbl[i].valid;
            step();
            ck("fp priority table", cap_ready[1], tbl[i].exp_fp);
        end
        idle(6);

        valid = 4'b1111;
        repeat (5) begin
            step();
            ck("fp all valid", cap_ready[1], 4'b0001);
        end
        idle(8);

        // Locked burst from req1 with a 2-cycle gap; req0 kept waiting.
        begin
            logic [N-1:0] sv [6], sl [6], se [6];
            sv = '{4'b0010, 4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
            sl = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
            se = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
            for (int i = 0; i < 6; i++) begin
                valid = sv[i]; lock = sl[i];
                step();
                ck("rr lock burst", cap_ready[0], se[i]);
                ck("fp lock burst", cap_ready[1], se[i]);
            end
        end
        idle(8);

        // Single beat through the RD_LAT=4 pipe.
        valid = 4'b0100;
        step();
        ck("fp single ready", cap_ready[1], 4'b0100);
        ck("fp idle busy", cap_busy[1], 0);
        valid = '0;
        for (int i = 1; i <= 6; i++) begin
            step();
            ck("fp lat4 rd_en", cap_en[1], (i == 1));
            ck("fp lat4 rsp", cap_rsp[1], (i == 5) ? 4'b0100 : 4'b0000);
            ck("fp lat4 busy", cap_busy[1], (i <= 5));
        end
        idle(4);

        // Reset with two reads in flight.
        valid = 4'b0011;
        repeat (2) step();
        valid = '0; resetn = 1'b0;
        step();
        ck("rr busy in reset", cap_busy[0], 0);
        ck("fp busy in reset", cap_busy[1], 0);
        resetn = 1'b1;
        repeat (6) begin
            step();
            ck("rr no stale rsp", cap_rsp[0], 0);
            ck("fp no stale rsp", cap_rsp[1], 0);
        end
        valid = 4'b0011;
        step();
        ck("rr ptr after reset", cap_ready[0], 4'b0001);
        valid = '0;
        step();
        ck("rr post-reset rd_en", cap_en[0], 1);
        ck("rr post-reset addr", cap_addr[0], 16'h0010);
        idle(6);

        // Random traffic with occasional locks and resets.
        for (int i = 0; i < 4000; i++) begin
            valid = N'($urandom);
            lock  = N'($urandom & $urandom & $urandom);
            addr  = {$urandom, $urandom};
            resetn = ($urandom_range(0, 499) != 0);
            step();
        end
        resetn = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
